// File: rtl/fma_pkg.sv
// ---------------------------------------------------------------------------
// fma_pkg
// Shared definitions for the FMA front end: precision encodings, exponent
// biases, canonical quiet-NaN patterns, the per-operand classification
// record and helpers that build special results right-aligned per precision.
// ---------------------------------------------------------------------------
package fma_pkg;

  // Precision select as carried on in_prec / out_prec. Both 00 and 11 mean double.
  typedef enum logic [1:0] {
    PREC_DOUBLE   = 2'b00,
    PREC_HALF     = 2'b01,
    PREC_SINGLE   = 2'b10,
    PREC_DOUBLE_X = 2'b11
  } fma_prec_e;

  // Exponent biases; the all-ones exponent of each format is 2*bias+1.
  localparam int DP_BIAS = 1023;
  localparam int SP_BIAS = 127;
  localparam int HP_BIAS = 15;

  localparam logic [10:0] DP_EXP_MAX = 11'(2 * DP_BIAS + 1);
  localparam logic [10:0] SP_EXP_MAX = 11'(2 * SP_BIAS + 1);
  localparam logic [10:0] HP_EXP_MAX = 11'(2 * HP_BIAS + 1);

  // Canonical quiet NaNs, right-aligned, upper bits zero.
  localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] SP_QNAN = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] HP_QNAN = 64'h0000_0000_0000_7E00;

  // Unpacked and classified view of one operand.
  typedef struct packed {
    logic        sign;
    logic [10:0] exp;   // biased, zero-extended; 0 for zero / flushed subnormal
    logic [52:0] mant;  // {hidden 1, fraction, zero pad}; 0 when zero
    logic        zero;  // true zero or flushed subnormal
    logic        inf;
    logic        nan;
    logic        snan;
  } fma_operand_t;

  // Canonical qNaN for the selected precision.
  function automatic logic [63:0] qnan_pattern(input logic [1:0] prec);
    logic [63:0] res;
    case (fma_prec_e'(prec))
      PREC_HALF:   res = HP_QNAN;
      PREC_SINGLE: res = SP_QNAN;
      default:     res = DP_QNAN;
    endcase
    return res;
  endfunction

  // Signed infinity for the selected precision, right-aligned.
  function automatic logic [63:0] inf_pattern(input logic [1:0] prec, input logic sign);
    logic [63:0] res;
    case (fma_prec_e'(prec))
      PREC_HALF:   res = {48'h0, sign, HP_EXP_MAX[4:0], 10'h0};
      PREC_SINGLE: res = {32'h0, sign, SP_EXP_MAX[7:0], 23'h0};
      default:     res = {sign, DP_EXP_MAX, 52'h0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fma_unpack.sv
// ---------------------------------------------------------------------------
// fma_unpack
// Combinational unpack/classify of one raw IEEE operand.
//   raw  : operand bits, right-aligned for the selected precision
//   prec : 01 half, 10 single, 00/11 double
//   op   : sign, zero-extended biased exponent, MSB-aligned hidden-bit
//          mantissa, and zero / inf / NaN / sNaN flags
// Subnormals are flushed: exponent 0, mantissa 0, zero flag set.
// ---------------------------------------------------------------------------
module fma_unpack
  import fma_pkg::*;
(
  input  logic [63:0]  raw,
  input  logic [1:0]   prec,
  output fma_operand_t op
);

  logic        sign_s;
  logic [10:0] exp_raw_s;
  logic [10:0] exp_max_s;
  logic [51:0] frac_s;     // fraction left-aligned so its MSB is always bit 51
  logic        exp_zero_s;
  logic        exp_ones_s;
  logic        frac_nz_s;

  // Field extraction: left-aligning the fraction lets the later logic ignore precision.
  always_comb begin
    case (fma_prec_e'(prec))
      PREC_HALF: begin
        sign_s    = raw[15];
        exp_raw_s = {6'h0, raw[14:10]};
        frac_s    = {raw[9:0], 42'h0};
        exp_max_s = HP_EXP_MAX;
      end
      PREC_SINGLE: begin
        sign_s    = raw[31];
        exp_raw_s = {3'h0, raw[30:23]};
        frac_s    = {raw[22:0], 29'h0};
        exp_max_s = SP_EXP_MAX;
      end
      default: begin
        sign_s    = raw[63];
        exp_raw_s = raw[62:52];
        frac_s    = raw[51:0];
        exp_max_s = DP_EXP_MAX;
      end
    endcase
  end

  assign exp_zero_s = (exp_raw_s == 11'h0);
  assign exp_ones_s = (exp_raw_s == exp_max_s);
  assign frac_nz_s  = (frac_s != 52'h0);

  // Classification; a zero exponent covers both true zero and flushed subnormal.
  always_comb begin
    op.sign = sign_s;
    op.zero = exp_zero_s;
    op.inf  = exp_ones_s & ~frac_nz_s;
    op.nan  = exp_ones_s & frac_nz_s;
    op.snan = exp_ones_s & frac_nz_s & ~frac_s[51];
    if (exp_zero_s) begin
      op.exp  = 11'h0;
      op.mant = 53'h0;
    end else begin
      op.exp  = exp_raw_s;
      op.mant = {1'b1, frac_s};
    end
  end

endmodule

// File: rtl/fma_operand_stage.sv
// ---------------------------------------------------------------------------
// fma_operand_stage
// Two-stage operand front end for a*b+c. S1 captures the raw triple, S2
// captures the unpacked fields plus the special-case result. Valid/ready on
// both sides, one triple per cycle, latency 2 cycles.
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : upstream handshake
//   in_a/in_b/in_c              : raw operands, right-aligned per in_prec
//   in_prec, in_tag             : precision select, opaque tag
//   out_valid/out_ready         : downstream handshake
//   out_sign/zero               : {c,b,a} signs / zero flags
//   out_exp_*/out_mant_*        : biased exponents / hidden-bit mantissas
//   out_prec, out_tag           : propagated with the operands
//   out_special/_res, invalid   : special-case result and invalid flag
// ---------------------------------------------------------------------------
module fma_operand_stage
  import fma_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_a,
  input  logic [63:0]       in_b,
  input  logic [63:0]       in_c,
  input  logic [1:0]        in_prec,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_sign,
  output logic [10:0]       out_exp_a,
  output logic [10:0]       out_exp_b,
  output logic [10:0]       out_exp_c,
  output logic [52:0]       out_mant_a,
  output logic [52:0]       out_mant_b,
  output logic [52:0]       out_mant_c,
  output logic [2:0]        out_zero,
  output logic [1:0]        out_prec,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_special,
  output logic [63:0]       out_special_res,
  output logic              out_invalid
);

  // Pipeline control
  logic              s1_valid_r;
  logic              s2_valid_r;
  logic              s1_load_s;
  logic              s2_load_s;

  // S1 raw capture
  logic [63:0]       s1_a_r;
  logic [63:0]       s1_b_r;
  logic [63:0]       s1_c_r;
  logic [1:0]        s1_prec_r;
  logic [TAG_W-1:0]  s1_tag_r;

  // Unpacked operands and special-case decision from S1 contents
  fma_operand_t      op_a_s;
  fma_operand_t      op_b_s;
  fma_operand_t      op_c_s;
  logic              any_nan_s;
  logic              any_snan_s;
  logic              inf_times_zero_s;
  logic              prod_inf_s;
  logic              prod_sign_s;
  logic              inf_cancel_s;
  logic              special_s;
  logic [63:0]       special_res_s;
  logic              invalid_s;

  // S2 result registers
  logic [2:0]        s2_sign_r;
  logic [10:0]       s2_exp_a_r;
  logic [10:0]       s2_exp_b_r;
  logic [10:0]       s2_exp_c_r;
  logic [52:0]       s2_mant_a_r;
  logic [52:0]       s2_mant_b_r;
  logic [52:0]       s2_mant_c_r;
  logic [2:0]        s2_zero_r;
  logic [1:0]        s2_prec_r;
  logic [TAG_W-1:0]  s2_tag_r;
  logic              s2_special_r;
  logic [63:0]       s2_special_res_r;
  logic              s2_invalid_r;

  // S2 accepts when empty or draining; S1 accepts when empty or moving into S2.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_load_s = ~s2_valid_r | out_ready;
  assign s1_load_s = ~s1_valid_r | s2_load_s;
  assign in_ready  = s1_load_s;

  // Stage valid flags; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s1_load_s) begin
        s1_valid_r <= in_valid;
      end
      if (s2_load_s) begin
        s2_valid_r <= s1_valid_r;
      end
    end
  end

  // S1 raw operand capture; contents are don't-care while s1_valid_r is low.
  always_ff @(posedge clk) begin
    if (s1_load_s && in_valid) begin
      s1_a_r    <= in_a;
      s1_b_r    <= in_b;
      s1_c_r    <= in_c;
      s1_prec_r <= in_prec;
      s1_tag_r  <= in_tag;
    end
  end

  fma_unpack u_unpack_a (.raw(s1_a_r), .prec(s1_prec_r), .op(op_a_s));
  fma_unpack u_unpack_b (.raw(s1_b_r), .prec(s1_prec_r), .op(op_b_s));
  fma_unpack u_unpack_c (.raw(s1_c_r), .prec(s1_prec_r), .op(op_c_s));

  assign any_nan_s        = op_a_s.nan | op_b_s.nan | op_c_s.nan;
  assign any_snan_s       = op_a_s.snan | op_b_s.snan | op_c_s.snan;
  assign inf_times_zero_s = (op_a_s.inf & op_b_s.zero) | (op_b_s.inf & op_a_s.zero);
  assign prod_inf_s       = (op_a_s.inf | op_b_s.inf) & ~inf_times_zero_s;
  assign prod_sign_s      = op_a_s.sign ^ op_b_s.sign;
  assign inf_cancel_s     = prod_inf_s & op_c_s.inf & (prod_sign_s ^ op_c_s.sign);

  // Special-case resolution: NaN inputs win, then invalid forms, then infinities.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 64'h0;
    invalid_s     = 1'b0;
    if (any_nan_s) begin
      special_s     = 1'b1;
      special_res_s = qnan_pattern(s1_prec_r);
      invalid_s     = any_snan_s;
    end else if (inf_times_zero_s || inf_cancel_s) begin
      special_s     = 1'b1;
      special_res_s = qnan_pattern(s1_prec_r);
      invalid_s     = 1'b1;
    end else if (prod_inf_s) begin
      special_s     = 1'b1;
      special_res_s = inf_pattern(s1_prec_r, prod_sign_s);
      invalid_s     = 1'b0;
    end else if (op_c_s.inf) begin
      special_s     = 1'b1;
      special_res_s = inf_pattern(s1_prec_r, op_c_s.sign);
      invalid_s     = 1'b0;
    end else begin
      special_s     = 1'b0;
      special_res_s = 64'h0;
      invalid_s     = 1'b0;
    end
  end

  // S2 result capture; cleared at reset so outputs read zero before first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign_r        <= 3'h0;
      s2_exp_a_r       <= 11'h0;
      s2_exp_b_r       <= 11'h0;
      s2_exp_c_r       <= 11'h0;
      s2_mant_a_r      <= 53'h0;
      s2_mant_b_r      <= 53'h0;
      s2_mant_c_r      <= 53'h0;
      s2_zero_r        <= 3'h0;
      s2_prec_r        <= 2'h0;
      s2_tag_r         <= '0;
      s2_special_r     <= 1'b0;
      s2_special_res_r <= 64'h0;
      s2_invalid_r     <= 1'b0;
    end else if (s2_load_s && s1_valid_r) begin
      s2_sign_r        <= {op_c_s.sign, op_b_s.sign, op_a_s.sign};
      s2_exp_a_r       <= op_a_s.exp;
      s2_exp_b_r       <= op_b_s.exp;
      s2_exp_c_r       <= op_c_s.exp;
      s2_mant_a_r      <= op_a_s.mant;
      s2_mant_b_r      <= op_b_s.mant;
      s2_mant_c_r      <= op_c_s.mant;
      s2_zero_r        <= {op_c_s.zero, op_b_s.zero, op_a_s.zero};
      s2_prec_r        <= s1_prec_r;
      s2_tag_r         <= s1_tag_r;
      s2_special_r     <= special_s;
      s2_special_res_r <= special_res_s;
      s2_invalid_r     <= invalid_s;
    end
  end

  assign out_valid       = s2_valid_r;
  assign out_sign        = s2_sign_r;
  assign out_exp_a       = s2_exp_a_r;
  assign out_exp_b       = s2_exp_b_r;
  assign out_exp_c       = s2_exp_c_r;
  assign out_mant_a      = s2_mant_a_r;
  assign out_mant_b      = s2_mant_b_r;
  assign out_mant_c      = s2_mant_c_r;
  assign out_zero        = s2_zero_r;
  assign out_prec        = s2_prec_r;
  assign out_tag         = s2_tag_r;
  assign out_special     = s2_special_r;
  assign out_special_res = s2_special_res_r;
  assign out_invalid     = s2_invalid_r;

endmodule

// File: tb/tb_fma_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_fma_operand_stage
// Randomized scoreboard bench: the driver pushes the reference-model result of
// every accepted triple, a separate monitor pops and compares each delivered
// output, and checks that stalled outputs hold. Directed checks cover reset,
// latency and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_fma_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = 64'h0, in_b = 64'h0, in_c = 64'h0;
  logic [1:0]  in_prec = 2'h0;
  logic [3:0]  in_tag = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_sign, out_zero;
  logic [10:0] out_exp_a, out_exp_b, out_exp_c;
  logic [52:0] out_mant_a, out_mant_b, out_mant_c;
  logic [1:0]  out_prec;
  logic [3:0]  out_tag;
  logic        out_special, out_invalid;
  logic [63:0] out_special_res;

  typedef struct packed {
    logic [2:0]  sign;
    logic [10:0] exp_a, exp_b, exp_c;
    logic [52:0] mant_a, mant_b, mant_c;
    logic [2:0]  zero;
    logic [1:0]  prec;
    logic [3:0]  tag;
    logic        special;
    logic [63:0] res;
    logic        invalid;
  } res_t;

  typedef struct {
    logic [63:0] a, b, c;
    logic [1:0]  prec;
    logic        chk;
    logic [63:0] res;
    logic        inv;
  } stim_t;

  typedef struct {
    res_t        r;
    logic        chk;
    logic [63:0] res;
    logic        inv;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;
  logic  ready_rand = 1'b0;
  logic  stream_done = 1'b0;

  fma_operand_stage #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_prec(in_prec), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp_a(out_exp_a), .out_exp_b(out_exp_b), .out_exp_c(out_exp_c),
    .out_mant_a(out_mant_a), .out_mant_b(out_mant_b), .out_mant_c(out_mant_c),
    .out_zero(out_zero), .out_prec(out_prec), .out_tag(out_tag),
    .out_special(out_special), .out_special_res(out_special_res), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  function automatic res_t dut_bundle();
    res_t r;
    r.sign = out_sign;   r.exp_a = out_exp_a; r.exp_b = out_exp_b; r.exp_c = out_exp_c;
    r.mant_a = out_mant_a; r.mant_b = out_mant_b; r.mant_c = out_mant_c;
    r.zero = out_zero;   r.prec = out_prec;   r.tag = out_tag;
    r.special = out_special; r.res = out_special_res; r.invalid = out_invalid;
    return r;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void fmt(input logic [1:0] prec, output int ew, output int fw);
    if (prec == 2'b01) begin ew = 5; fw = 10; end
    else if (prec == 2'b10) begin ew = 8; fw = 23; end
    else begin ew = 11; fw = 52; end
  endfunction

  // Reference: IEEE field arithmetic and the special-case rules stated as priorities.
  function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [1:0] prec,
                                     input logic [3:0] tag);
    res_t r;
    int ew, fw;
    logic [63:0] ops[3];
    logic [63:0] x, e, f, emax, qn;
    logic [63:0] ev[3], mv[3];
    logic sg[3], zr[3], nn[3], nf[3], sn[3];
    logic psign, iz, pinf;
    ops[0] = a; ops[1] = b; ops[2] = c;
    fmt(prec, ew, fw);
    emax = (64'd1 << ew) - 64'd1;
    for (int i = 0; i < 3; i++) begin
      x = ops[i];
      sg[i] = x[ew + fw];
      e = (x >> fw) & emax;
      f = x & ((64'd1 << fw) - 64'd1);
      zr[i] = (e == 64'd0);
      nn[i] = (e == emax) && (f != 64'd0);
      nf[i] = (e == emax) && (f == 64'd0);
      sn[i] = nn[i] && (f[fw - 1] == 1'b0);
      ev[i] = zr[i] ? 64'd0 : e;
      mv[i] = zr[i] ? 64'd0 : ((64'd1 << 52) | (f << (52 - fw)));
    end
    r = '0;
    r.sign = {sg[2], sg[1], sg[0]};
    r.exp_a = ev[0][10:0]; r.exp_b = ev[1][10:0]; r.exp_c = ev[2][10:0];
    r.mant_a = mv[0][52:0]; r.mant_b = mv[1][52:0]; r.mant_c = mv[2][52:0];
    r.zero = {zr[2], zr[1], zr[0]};
    r.prec = prec; r.tag = tag;
    qn = (prec == 2'b01) ? 64'h7E00 : (prec == 2'b10) ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
    iz = (nf[0] && zr[1]) || (nf[1] && zr[0]);
    psign = sg[0] ^ sg[1];
    pinf = (nf[0] || nf[1]) && !iz;
    if (nn[0] || nn[1] || nn[2]) begin
      r.special = 1'b1; r.res = qn; r.invalid = sn[0] || sn[1] || sn[2];
    end else if (iz || (pinf && nf[2] && (psign != sg[2]))) begin
      r.special = 1'b1; r.res = qn; r.invalid = 1'b1;
    end else if (pinf) begin
      r.special = 1'b1; r.res = ({63'd0, psign} << (ew + fw)) | (emax << fw);
    end else if (nf[2]) begin
      r.special = 1'b1; r.res = ({63'd0, sg[2]} << (ew + fw)) | (emax << fw);
    end
    return r;
  endfunction

  // Random operand biased toward the interesting classes.
  function automatic logic [63:0] gen_op(input logic [1:0] prec);
    int ew, fw, emax_i, cls;
    logic [63:0] s, e, f, msb;
    fmt(prec, ew, fw);
    emax_i = (1 << ew) - 1;
    cls = $urandom_range(0, 7);
    s = 64'($urandom_range(0, 1));
    f = {$urandom(), $urandom()} & ((64'd1 << fw) - 64'd1);
    msb = 64'd1 << (fw - 1);
    case (cls)
      0: begin e = 64'd0; f = 64'd0; end
      1: begin e = 64'd0; f = f | 64'd1; end
      5: begin e = 64'(emax_i); f = 64'd0; end
      6: begin e = 64'(emax_i); f = f | msb; end
      7: begin e = 64'(emax_i); f = (f & ~msb) | 64'd1; end
      default: e = 64'($urandom_range(1, emax_i - 1));
    endcase
    return (s << (ew + fw)) | (e << fw) | f;
  endfunction

  // Monitor: pop and compare every delivered result; stalled outputs must hold.
  initial begin
    res_t snap;
    logic stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_hold", {out_valid, dut_bundle()}, {1'b1, snap});
        stalled = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {256'd0, 60'd0, out_tag}, 320'd0 - 320'd1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("scoreboard", dut_bundle(), e.r);
            if (e.chk) check("directed_res_inv", {out_special_res, out_invalid}, {e.res, e.inv});
          end
        end else if (out_valid) begin
          snap = dut_bundle();
          stalled = 1'b1;
        end
      end
    end
  end

  // out_ready pattern: toggling every cycle first, random later.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ~out_ready;
    end
  end

  task automatic add_stim(input logic [63:0] a, b, c, input logic [1:0] p,
                          input logic chk, input logic [63:0] res, input logic inv);
    stim_t s;
    s.a = a; s.b = b; s.c = c; s.prec = p; s.chk = chk; s.res = res; s.inv = inv;
    stim_q.push_back(s);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [3:0] tag_cnt;
    stim_t s;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {319'd0, out_valid}, 320'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {319'd0, in_ready}, 320'd1);
    check("reset_data_zero", {50'd0, dut_bundle()}, 320'd0);

    // Latency: DP 1.0 * 2.0 + 0
    @(negedge clk);
    in_a = 64'h3FF0_0000_0000_0000; in_b = 64'h4000_0000_0000_0000; in_c = 64'h0;
    in_prec = 2'b00; in_tag = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("lat_in_ready", {319'd0, in_ready}, 320'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("latency_cycles", 320'(cyc), 320'd2);
    check("dp_exp_a", {309'd0, out_exp_a}, {309'd0, 11'h3FF});
    check("dp_mant_a", {267'd0, out_mant_a}, {267'd0, 53'h10_0000_0000_0000});
    check("dp_special", {319'd0, out_special}, 320'd0);
    check("dp_bundle", {50'd0, dut_bundle()},
          {50'd0, ref_model(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0, 2'b00, 4'h5)});
    @(negedge clk);
    check("dp_drained", {319'd0, out_valid}, 320'd0);

    // Fill both stages while stalled, then reset
    out_ready = 1'b0;
    in_a = 64'h3C00; in_b = 64'h3C00; in_c = 64'h3C00; in_prec = 2'b01;
    in_tag = 4'h1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_tag = 4'h2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_out_valid", {319'd0, out_valid}, 320'd1);
    check("full_in_ready", {319'd0, in_ready}, 320'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", {319'd0, out_valid}, 320'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", {319'd0, in_ready}, 320'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_stale_output", 320'(seen), 320'd0);

    // Streaming phase: directed vectors, 8 back-to-back, then random
    add_stim(64'h7F80_0000, 64'h0, 64'h3F80_0000, 2'b10, 1'b1, 64'h7FC0_0000, 1'b1);
    add_stim(64'h7C00, 64'h3C00, 64'hFC00, 2'b01, 1'b1, 64'h7E00, 1'b1);
    add_stim(64'h7C00, 64'h3C00, 64'h7C00, 2'b01, 1'b1, 64'h7C00, 1'b0);
    add_stim(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h0, 2'b00, 1'b1,
             64'h7FF8_0000_0000_0000, 1'b1);
    add_stim(64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h0, 2'b00, 1'b1, 64'h0, 1'b0);
    for (int i = 0; i < 308; i++) begin
      logic [1:0] p;
      p = 2'($urandom_range(0, 3));
      add_stim(gen_op(p), gen_op(p), gen_op(p), p, 1'b0, 64'h0, 1'b0);
    end

    out_ready = 1'b1;
    mon_en = 1'b1;
    tag_cnt = 4'h0;
    for (int idx = 0; stim_q.size() > 0; idx++) begin
      @(negedge clk);
      if (idx == 40) ready_rand = 1'b1;
      if (idx >= 13 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        exp_t e;
        s = stim_q.pop_front();
        in_a = s.a; in_b = s.b; in_c = s.c; in_prec = s.prec; in_tag = tag_cnt;
        in_valid = 1'b1;
        #1;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
          @(negedge clk);
          #1;
          cyc++;
        end
        if (cyc >= 200) check("in_ready_timeout", 320'(cyc), 320'd0);
        e.r = ref_model(s.a, s.b, s.c, s.prec, tag_cnt);
        e.chk = s.chk; e.res = s.res; e.inv = s.inv;
        exp_q.push_back(e);
        tag_cnt = tag_cnt + 4'h1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("scoreboard_drained", 320'(exp_q.size()), 320'd0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    stream_done = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got stream_done=%0d expected 1", stream_done);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fma_operand_stage.md
FMA_OPERAND_STAGE -- requirements
Module: fma_operand_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the transaction tag carried alongside the operands.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  upstream presents an operand triple; in_ready  out  1  stage can accept.
REQ-005 in_a, in_b, in_c  in  64 each  raw operands of a*b+c, right-aligned per precision.
REQ-006 in_prec  in  2  01=half, 10=single, 00/11=double; in_tag  in  TAG_W  opaque tag.
REQ-007 out_valid  out  1  result present; out_ready  in  1  downstream accepts.
REQ-008 out_sign  out  3  {c,b,a} signs; out_exp_a/b/c  out  11 each  biased exponents; out_mant_a/b/c  out  53 each  hidden-bit mantissas, MSB-aligned.
REQ-009 out_zero  out  3  {c,b,a} zero (including flushed subnormal); out_prec  out  2; out_tag  out  TAG_W.
REQ-010 out_special  out  1  result fully determined by special-case logic; out_special_res  out  64  that result, right-aligned per out_prec; out_invalid  out  1  IEEE invalid-operation flag.

Function
REQ-011 SHALL be a two-stage pipeline: S1 registers raw inputs; S2 registers unpacked fields and special-case results; latency in_valid&in_ready to out_valid = 2 cycles.
REQ-012 Transfer occurs on valid&ready on each side; out_* SHALL be held stable while out_valid & ~out_ready.
REQ-013 S2 loads when ~s2_valid | out_ready; S1 loads when ~s1_valid | S2 loads; in_ready = ~s1_valid | S2 loads (full throughput, one triple per cycle, no combinational path from in_valid to in_ready).
REQ-014 Simultaneous S2 drain and S1 fill in one cycle SHALL lose and duplicate nothing.
REQ-015 Unpack per precision: exponent zero-extended to 11 bits; mantissa = {1, fraction, zero pad} when exponent non-zero; subnormals flushed to zero with exponent 0 and out_zero set.
REQ-016 NaN: exponent all-ones and fraction non-zero; inf: exponent all-ones and fraction zero; sNaN: NaN with fraction MSB 0.
REQ-017 Any NaN operand SHALL give out_special=1, out_special_res = canonical qNaN (DP 7FF8_0000_0000_0000, SP 7FC0_0000, HP 7E00, upper bits zero).
REQ-018 out_invalid=1 on: any sNaN; inf*0 (a inf & b zero or vice versa); product inf and c inf with sign_a^sign_b != sign_c; the latter two also give qNaN.
REQ-019 Product inf (no NaN, no invalid): out_special=1, result inf with sign sign_a^sign_b; c inf with finite product: result inf with sign_c.
REQ-020 All other cases SHALL give out_special=0, out_special_res=0, out_invalid=0.
REQ-021 in_tag and in_prec SHALL propagate unchanged with their operands.

Reset
REQ-022 rst_n low SHALL asynchronously clear s1_valid, s2_valid; out_valid=0 and in_ready=1 after release; data registers need no reset, but out_* data SHALL read 0 out of reset.
REQ-023 Reset asserted mid-transfer SHALL discard in-flight triples; no output after release until new input accepted.

Structure
REQ-024 Precision encodings, bias constants (1023/127/15) and canonical qNaN patterns SHALL live in shared package fma_pkg.
REQ-025 Per-operand unpack/classify SHALL be one sub-module, fma_unpack, instantiated three times in S2.

Verification
REQ-026 DP a=3FF0..0 (1.0), b=4000..0 (2.0), c=0: out_valid at cycle +2, exp_a=3FF, mant_a=1<<52, out_special=0.
REQ-027 SP a=7F800000 (inf), b=0, c=3F800000: out_special=1, out_special_res=7FC00000, out_invalid=1.
REQ-028 HP a=7C00, b=3C00, c=FC00 (inf - inf): res 7E00, invalid=1; with c=7C00: res 7C00, invalid=0.
REQ-029 Back-to-back 8 triples with out_ready toggled 1/0 every cycle: all 8 tags out in order, none lost or duplicated, outputs stable while stalled.
REQ-030 DP a=7FF0_0000_0000_0001 (sNaN): res 7FF8_0000_0000_0000, invalid=1; a=0000_0000_0000_0001 (subnormal): out_zero[0]=1, exp_a=0.
REQ-031 rst_n pulsed low with both stages full: out_valid drops immediately, in_ready=1 after release, no stale output.
